// File: rtl/tartaruga_pkg.sv
// tartaruga_pkg: shared types and constants for the tartaruga pipeline memory port
package tartaruga_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT_I, ARB_WAIT_D, ARB_WAIT_DROP} arb_state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } mem_req_t;
  localparam int unsigned ARB_STARVE_MAX_DEFAULT = 4;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data with data priority and fetch anti-starvation
module mem_port_arbiter
  import tartaruga_pkg::*;
#(
  parameter int unsigned STARVE_MAX = ARB_STARVE_MAX_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        flush_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_be_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_gnt_o,
  output logic        dm_rvalid_o,
  output logic [31:0] dm_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);
  arb_state_t state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       idle, starved, sel_d, sel_i;
  mem_req_t   req;
  assign idle    = rstn_i && state_q == ARB_IDLE;
  assign starved = starve_q == 4'(STARVE_MAX) && if_req_i && !flush_i;
  assign sel_d   = idle && dm_req_i && !starved;
  assign sel_i   = idle && if_req_i && !flush_i && !sel_d;
  assign req = sel_d ? mem_req_t'{addr: dm_addr_i, wdata: dm_wdata_i, be: dm_be_i, we: dm_we_i}
             : sel_i ? mem_req_t'{addr: if_addr_i, wdata: 32'h0, be: 4'hf, we: 1'b0}
             : '0;
  assign mem_req_o   = sel_d | sel_i;
  assign mem_we_o    = req.we;
  assign mem_be_o    = req.be;
  assign mem_addr_o  = req.addr;
  assign mem_wdata_o = req.wdata;
  assign if_gnt_o    = mem_gnt_i & sel_i;
  assign dm_gnt_o    = mem_gnt_i & sel_d;
  assign if_rvalid_o = rstn_i && state_q == ARB_WAIT_I && mem_rvalid_i && !flush_i;
  assign dm_rvalid_o = rstn_i && state_q == ARB_WAIT_D && mem_rvalid_i;
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'h0;
  assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : 32'h0;
  always_comb begin
    state_d  = if_gnt_o ? ARB_WAIT_I
             : dm_gnt_o ? ARB_WAIT_D
             : (state_q == ARB_IDLE || mem_rvalid_i) ? ARB_IDLE
             : (state_q == ARB_WAIT_I && flush_i) ? ARB_WAIT_DROP
             : state_q;
    starve_d = (if_gnt_o || !if_req_i) ? 4'd0
             : (dm_gnt_o && starve_q != 4'(STARVE_MAX)) ? starve_q + 4'd1
             : starve_q;
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ARB_IDLE;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed plan scenarios plus random traffic checked against a transaction-level model
module tb_mem_port_arbiter;
  import tartaruga_pkg::*;
  localparam int SM = 4;
  logic clk = 1'b0, rstn, flush, if_req, dm_req, dm_we, mem_gnt, mem_rvalid;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0] dm_be;
  logic if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  int tests = 0, fails = 0;
  int starve = 0;
  bit busy = 0, busy_d = 0, killed = 0;
  logic e_ig, e_dg, e_iv, e_dv, e_req, e_we;
  logic [3:0] e_be;
  logic [31:0] e_addr, e_wdata;
  logic s_ig, s_dg, s_iv, s_dv;
  logic [31:0] s_ird, s_drd;
  bit pi = 0, pd = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.STARVE_MAX(SM)) dut (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_be_i(dm_be), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_gnt_o(dm_gnt), .dm_rvalid_o(dm_rvalid), .dm_rdata_o(dm_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    logic fi, wd, wi;
    @(negedge clk);
    #1;
    {e_ig, e_dg, e_iv, e_dv, e_req, e_we, e_be, e_addr, e_wdata} = '0;
    if (rstn && !busy) begin
      fi = if_req && !flush;
      wd = dm_req && !(starve >= SM && fi);
      wi = fi && !wd;
      e_req = wd || wi;
      e_we = wd && dm_we;
      e_be = wd ? dm_be : wi ? 4'hf : 4'h0;
      e_addr = wd ? dm_addr : wi ? if_addr : 32'h0;
      e_wdata = wd ? dm_wdata : 32'h0;
      e_dg = wd && mem_gnt;
      e_ig = wi && mem_gnt;
    end else if (rstn) begin
      e_dv = mem_rvalid && busy_d;
      e_iv = mem_rvalid && !busy_d && !killed && !flush;
    end
    chk("if_gnt", 32'(if_gnt), 32'(e_ig));
    chk("dm_gnt", 32'(dm_gnt), 32'(e_dg));
    chk("if_rvalid", 32'(if_rvalid), 32'(e_iv));
    chk("dm_rvalid", 32'(dm_rvalid), 32'(e_dv));
    chk("if_rdata", if_rdata, e_iv ? mem_rdata : 32'h0);
    chk("dm_rdata", dm_rdata, e_dv ? mem_rdata : 32'h0);
    chk("mem_req", 32'(mem_req), 32'(e_req));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_be", 32'(mem_be), 32'(e_be));
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    {s_ig, s_dg, s_iv, s_dv, s_ird, s_drd} = {if_gnt, dm_gnt, if_rvalid, dm_rvalid, if_rdata, dm_rdata};
    @(posedge clk);
    if (!rstn) begin
      starve = 0;
      busy = 0;
      killed = 0;
    end else begin
      starve = (e_ig || !if_req) ? 0 : (e_dg && if_req) ? ((starve + 1 > SM) ? SM : starve + 1) : starve;
      if (busy) begin
        if (mem_rvalid) busy = 0;
        else if (!busy_d && flush) killed = 1;
      end else if (e_ig || e_dg) begin
        busy = 1;
        busy_d = e_dg;
        killed = 0;
      end
    end
    #1;
  endtask
  task automatic idle_in();
    {flush, if_req, dm_req, dm_we, mem_gnt, mem_rvalid} = '0;
    {if_addr, dm_addr, dm_wdata, mem_rdata, dm_be} = '0;
  endtask
  initial begin
    idle_in();
    rstn = 1'b0;
    {if_req, dm_req, mem_gnt, mem_rvalid, mem_rdata} = {4'hf, 32'h1234};
    cyc();
    cyc();
    idle_in();
    rstn = 1'b1;
    cyc();
    if_req = 1; if_addr = 32'h100; mem_gnt = 1;
    cyc();
    chk("plan1_gnt", 32'(s_ig), 32'd1);
    if_req = 0; mem_rvalid = 1; mem_rdata = 32'h13;
    cyc();
    chk("plan1_rvalid", 32'(s_iv), 32'd1);
    chk("plan1_rdata", s_ird, 32'h13);
    if_req = 1; if_addr = 32'h104; mem_rvalid = 0;
    cyc();
    chk("plan1_next_gnt", 32'(s_ig), 32'd1);
    if_req = 0; mem_rvalid = 1; cyc();
    if_req = 1; dm_req = 1; dm_addr = 32'h2000; mem_rvalid = 0;
    cyc();
    chk("plan2_dgnt", 32'(s_dg), 32'd1);
    chk("plan2_ignt", 32'(s_ig), 32'd0);
    dm_req = 0; mem_rvalid = 1; mem_rdata = 32'h55aa;
    cyc();
    chk("plan2_drv", 32'(s_dv), 32'd1);
    mem_rvalid = 0;
    cyc();
    chk("plan2_ignt_after", 32'(s_ig), 32'd1);
    mem_rvalid = 1; if_req = 0; cyc();
    if_req = 1; dm_req = 1; mem_gnt = 1; mem_rvalid = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (i % 2 == 0) chk("plan3_owner", {30'h0, s_ig, s_dg}, (i == 8) ? 32'd2 : 32'd1);
    end
    chk("plan3_starve_zero", 32'(dut.starve_q), 32'd0);
    idle_in();
    cyc();
    if_req = 1; if_addr = 32'h200; mem_gnt = 1;
    cyc();
    chk("plan4_gnt", 32'(s_ig), 32'd1);
    if_req = 0; flush = 1;
    cyc();
    flush = 0; mem_rvalid = 1; mem_rdata = 32'hdeadbeef;
    cyc();
    chk("plan4_dropped", 32'(s_iv), 32'd0);
    chk("plan4_idle", 32'(dut.state_q), 32'(ARB_IDLE));
    mem_rvalid = 0; if_req = 1; if_addr = 32'h300;
    cyc();
    chk("plan4_regnt", 32'(s_ig), 32'd1);
    if_req = 0; mem_rvalid = 1; cyc();
    idle_in();
    dm_req = 1; dm_we = 1; dm_be = 4'b0011; dm_addr = 32'h40; dm_wdata = 32'hcafebabe; mem_gnt = 1;
    cyc();
    chk("plan5_sgnt", 32'(s_dg), 32'd1);
    dm_req = 0; flush = 1;
    cyc();
    mem_rvalid = 1;
    cyc();
    chk("plan5_ack", 32'(s_dv), 32'd1);
    mem_rvalid = 0; if_req = 1;
    cyc();
    chk("plan5_flush_ignt", 32'(s_ig), 32'd0);
    idle_in();
    dm_req = 1; dm_addr = 32'h80; mem_gnt = 1;
    cyc();
    dm_req = 0; rstn = 0;
    cyc();
    rstn = 1; mem_rvalid = 1; mem_rdata = 32'h77;
    cyc();
    chk("plan6_no_pulse", {30'h0, s_iv, s_dv}, 32'd0);
    mem_rvalid = 0; dm_req = 1;
    cyc();
    chk("plan6_first_gnt", 32'(s_dg), 32'd1);
    dm_req = 0; mem_rvalid = 1; cyc();
    idle_in();
    for (int n = 0; n < 3000; n++) begin
      rstn = ($urandom_range(199) != 0);
      if (!pi && $urandom_range(2) == 0) begin
        pi = 1;
        if_addr = $urandom & 32'hffff_fffc;
      end
      if (!pd && $urandom_range(2) == 0) begin
        pd = 1;
        dm_we = 1'($urandom);
        dm_be = 4'($urandom);
        dm_addr = $urandom;
        dm_wdata = $urandom;
      end
      if_req = pi;
      dm_req = pd;
      flush = ($urandom_range(7) == 0);
      mem_gnt = ($urandom_range(3) != 0);
      mem_rvalid = busy ? 1'($urandom) : ($urandom_range(9) == 0);
      mem_rdata = $urandom;
      cyc();
      if (s_ig || flush || !rstn) pi = 0;
      if (s_dg || !rstn) pd = 0;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
